// File: rtl/gactx_arb_pkg.sv
// Shared types and widths for the GACT-X tile arbiter.
package gactx_arb_pkg;

  localparam int TILE_OUT_W = 512;
  localparam int DIR_W      = 128;
  localparam int SEQ_W      = 64;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/gactx_rr_pick.sv
// Combinational round-robin pick: first requesting index at or after pointer.
module gactx_rr_pick #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [LOG_NUM_REQ-1:0] pointer,
  output logic                   valid,
  output logic [LOG_NUM_REQ-1:0] index
);

  logic [LOG_NUM_REQ:0]   w_sum [NUM_REQ];
  logic [LOG_NUM_REQ-1:0] w_idx [NUM_REQ];
  logic [NUM_REQ-1:0]     w_hit;

  // Candidate gi is the requester gi positions after the pointer, wrapped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_sum[gi] = {1'b0, pointer} + (LOG_NUM_REQ+1)'(gi);
      assign w_idx[gi] = (w_sum[gi] >= (LOG_NUM_REQ+1)'(NUM_REQ))
                       ? LOG_NUM_REQ'(w_sum[gi] - (LOG_NUM_REQ+1)'(NUM_REQ))
                       : w_sum[gi][LOG_NUM_REQ-1:0];
      assign w_hit[gi] = req[w_idx[gi]];
    end
  endgenerate

  always_comb begin
    valid = |w_hit;
    index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_hit[i]) index = w_idx[i];
    end
  end

endmodule

// File: rtl/gactx_tile_arbiter.sv
// Round-robin owner arbitration of one GACT-X array among NUM_REQ requesters.
// Optional watchdog on RUN/DRAIN enabled by defining GACTX_ARB_TIMEOUT_EN.
module gactx_tile_arbiter
  import gactx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LOG_NUM_REQ    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [NUM_REQ-1:0]          req_start,
  input  logic [NUM_REQ-1:0]          req_ref_wr_en,
  input  logic [NUM_REQ-1:0]          req_query_wr_en,
  input  logic [SEQ_W*NUM_REQ-1:0]    req_ref_in,
  input  logic [SEQ_W*NUM_REQ-1:0]    req_query_in,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_ref_addr,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_query_addr,
  output logic                        arr_start,
  output logic                        arr_ref_wr_en,
  output logic                        arr_query_wr_en,
  output logic                        arr_clear_done,
  output logic [SEQ_W-1:0]            arr_ref_in,
  output logic [SEQ_W-1:0]            arr_query_in,
  output logic [ADDR_W-1:0]           arr_ref_addr,
  output logic [ADDR_W-1:0]           arr_query_addr,
  input  logic                        arr_ready,
  input  logic                        arr_done,
  input  logic [TILE_OUT_W-1:0]       arr_tile_output,
  input  logic [CNT_W-1:0]            arr_dir_out_count,
  input  logic [DIR_W-1:0]            arr_dir_out,
  input  logic                        arr_dir_out_valid,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [TILE_OUT_W-1:0]       rsp_tile_output,
  output logic                        rsp_error,
  output logic [NUM_REQ-1:0]          dir_valid,
  output logic [DIR_W-1:0]            dir_data,
  output logic                        busy,
  output logic [LOG_NUM_REQ-1:0]      owner_id
);

`ifdef GACTX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e               r_state;
  arb_state_e               w_state_next;
  logic [LOG_NUM_REQ-1:0]   r_ptr;
  logic [LOG_NUM_REQ-1:0]   r_owner;
  logic [TILE_OUT_W-1:0]    r_rsp_tile;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic [CNT_W-1:0]         r_beat_total;
  logic [DIR_W-1:0]         r_dir_data;
  logic [NUM_REQ-1:0]       r_dir_valid;
  logic [CNT_W-1:0]         r_tmo_cnt;
  logic                     r_err;

  logic                     w_pick_valid;
  logic [LOG_NUM_REQ-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0]       w_owner_oh;
  logic [LOG_NUM_REQ-1:0]   w_owner_inc;
  logic                     w_start_ok;
  logic                     w_abort;
  logic                     w_drain_done;
  logic                     w_in_exec;
  logic                     w_tmo_hit;

  logic [SEQ_W-1:0]         w_ref_word   [NUM_REQ];
  logic [SEQ_W-1:0]         w_query_word [NUM_REQ];
  logic [ADDR_W-1:0]        w_ref_adr    [NUM_REQ];
  logic [ADDR_W-1:0]        w_query_adr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_ref_word[gi]   = req_ref_in[gi*SEQ_W +: SEQ_W];
      assign w_query_word[gi] = req_query_in[gi*SEQ_W +: SEQ_W];
      assign w_ref_adr[gi]    = req_ref_addr[gi*ADDR_W +: ADDR_W];
      assign w_query_adr[gi]  = req_query_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  gactx_rr_pick #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ)
  ) u_pick (
    .req     (req),
    .pointer (r_ptr),
    .valid   (w_pick_valid),
    .index   (w_pick_idx)
  );

  assign w_owner_oh   = NUM_REQ'(1) << r_owner;
  assign w_owner_inc  = (r_owner == LOG_NUM_REQ'(NUM_REQ - 1)) ? '0 : r_owner + LOG_NUM_REQ'(1);
  assign w_start_ok   = (r_state == LOAD) && req_start[r_owner] && arr_ready;
  assign w_abort      = (r_state == LOAD) && !w_start_ok && !req[r_owner];
  assign w_drain_done = (r_beat_cnt == r_beat_total);
  assign w_in_exec    = (r_state == RUN) || (r_state == DRAIN);
  assign w_tmo_hit    = TIMEOUT_EN && w_in_exec && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_pick_valid) w_state_next = LOAD;
      LOAD: begin
        if (w_start_ok)        w_state_next = RUN;
        else if (w_abort)      w_state_next = IDLE;
      end
      RUN: begin
        if (w_tmo_hit)         w_state_next = RESP;
        else if (arr_done)     w_state_next = (arr_dir_out_count == '0) ? RESP : DRAIN;
      end
      DRAIN: begin
        if (w_tmo_hit || w_drain_done) w_state_next = RESP;
      end
      RESP:                    w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Outputs are all gated by state so that reset (IDLE) forces them to zero.
  always_comb begin
    gnt             = '0;
    arr_start       = 1'b0;
    arr_ref_wr_en   = 1'b0;
    arr_query_wr_en = 1'b0;
    arr_clear_done  = 1'b0;
    arr_ref_in      = '0;
    arr_query_in    = '0;
    arr_ref_addr    = '0;
    arr_query_addr  = '0;
    rsp_valid       = '0;
    rsp_error       = 1'b0;
    case (r_state)
      LOAD: begin
        gnt             = w_owner_oh;
        arr_start       = w_start_ok;
        arr_ref_wr_en   = req_ref_wr_en[r_owner];
        arr_query_wr_en = req_query_wr_en[r_owner];
        arr_ref_in      = w_ref_word[r_owner];
        arr_query_in    = w_query_word[r_owner];
        arr_ref_addr    = w_ref_adr[r_owner];
        arr_query_addr  = w_query_adr[r_owner];
      end
      RUN, DRAIN: gnt = w_owner_oh;
      RESP: begin
        gnt            = w_owner_oh;
        rsp_valid      = w_owner_oh;
        arr_clear_done = 1'b1;
        rsp_error      = TIMEOUT_EN && r_err;
      end
      default: ;
    endcase
  end

  assign busy            = |gnt;
  assign owner_id        = r_owner;
  assign rsp_tile_output = r_rsp_tile;
  assign dir_valid       = r_dir_valid;
  assign dir_data        = r_dir_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_owner      <= '0;
      r_rsp_tile   <= '0;
      r_beat_cnt   <= '0;
      r_beat_total <= '0;
      r_dir_data   <= '0;
      r_dir_valid  <= '0;
      r_tmo_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_dir_valid <= '0;
      if (r_state == IDLE && w_pick_valid) r_owner <= w_pick_idx;
      if (w_abort || r_state == RESP)      r_ptr   <= w_owner_inc;
      if (r_state == RUN && arr_done && !w_tmo_hit) begin
        r_rsp_tile   <= arr_tile_output;
        r_beat_total <= arr_dir_out_count;
        r_beat_cnt   <= '0;
      end
      // Beats beyond the announced count are dropped; the counter never wraps.
      if (r_state == DRAIN && arr_dir_out_valid && !w_drain_done && !w_tmo_hit) begin
        r_dir_data  <= arr_dir_out;
        r_dir_valid <= w_owner_oh;
        r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
      end
      if (TIMEOUT_EN && w_in_exec) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      else                         r_tmo_cnt <= '0;
      if (w_tmo_hit)               r_err <= 1'b1;
      else if (r_state == RESP)    r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gactx_tile_arbiter.sv
// Self-checking bench for gactx_tile_arbiter: vector table plus corner sequences.
module tb_gactx_tile_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   gnt;
  logic [3:0]   req_start = '0;
  logic [3:0]   req_ref_wr_en = '0;
  logic [3:0]   req_query_wr_en = '0;
  logic [255:0] req_ref_in = '0;
  logic [255:0] req_query_in = '0;
  logic [127:0] req_ref_addr = '0;
  logic [127:0] req_query_addr = '0;
  logic         arr_start, arr_ref_wr_en, arr_query_wr_en, arr_clear_done;
  logic [63:0]  arr_ref_in, arr_query_in;
  logic [31:0]  arr_ref_addr, arr_query_addr;
  logic         arr_ready = 1'b0;
  logic         arr_done = 1'b0;
  logic [511:0] arr_tile_output = '0;
  logic [31:0]  arr_dir_out_count = '0;
  logic [127:0] arr_dir_out = '0;
  logic         arr_dir_out_valid = 1'b0;
  logic [3:0]   rsp_valid;
  logic [511:0] rsp_tile_output;
  logic         rsp_error;
  logic [3:0]   dir_valid;
  logic [127:0] dir_data;
  logic         busy;
  logic [1:0]   owner_id;

  gactx_tile_arbiter #(
    .NUM_REQ(4), .LOG_NUM_REQ(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .req_start(req_start),
    .req_ref_wr_en(req_ref_wr_en), .req_query_wr_en(req_query_wr_en),
    .req_ref_in(req_ref_in), .req_query_in(req_query_in),
    .req_ref_addr(req_ref_addr), .req_query_addr(req_query_addr),
    .arr_start(arr_start), .arr_ref_wr_en(arr_ref_wr_en), .arr_query_wr_en(arr_query_wr_en),
    .arr_clear_done(arr_clear_done), .arr_ref_in(arr_ref_in), .arr_query_in(arr_query_in),
    .arr_ref_addr(arr_ref_addr), .arr_query_addr(arr_query_addr),
    .arr_ready(arr_ready), .arr_done(arr_done), .arr_tile_output(arr_tile_output),
    .arr_dir_out_count(arr_dir_out_count), .arr_dir_out(arr_dir_out),
    .arr_dir_out_valid(arr_dir_out_valid), .rsp_valid(rsp_valid),
    .rsp_tile_output(rsp_tile_output), .rsp_error(rsp_error), .dir_valid(dir_valid),
    .dir_data(dir_data), .busy(busy), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_rsp;
    logic [3:0]   oh;
    logic [511:0] tile;
    logic [127:0] dir;
    bit           err;
    bit           chk_tile;
  } exp_t;

  typedef struct {
    int           id;
    logic [511:0] tile;
    int           ndir;
    logic [127:0] dbase;
    bit           notready;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_starts = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Output monitor: pops the scoreboard on every forwarded beat or response.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_tests++;
      if (!$onehot0(gnt) || (busy !== |gnt)) begin
        n_fail++;
        $display("FAIL gnt_onehot: gnt=%b busy=%b", gnt, busy);
      end
    end
    if (arr_start === 1'b1) n_starts++;
    if (dir_valid !== 4'b0) begin
      if (sb.size() == 0 || sb[0].is_rsp) begin
        n_tests++; n_fail++;
        $display("FAIL dir_unexpected: dir_valid=%b data=%0h", dir_valid, dir_data);
      end else begin
        e = sb.pop_front();
        chk("dir_beat", {dir_valid, dir_data}, {e.oh, e.dir});
      end
    end
    if (rsp_valid !== 4'b0) begin
      if (sb.size() == 0 || !sb[0].is_rsp) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=%b", rsp_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", {rsp_valid, rsp_error, arr_clear_done}, {e.oh, e.err, 1'b1});
        if (e.chk_tile) chk("rsp_tile", rsp_tile_output, e.tile);
      end
    end
  end

  task automatic wait_grant(input int id, output int lat);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (gnt !== 4'b0) break;
    end
    chk("grant", {gnt, 2'b0, owner_id, 3'b0, busy}, {4'(1) << id, 2'b0, 2'(id), 3'b0, 1'b1});
  endtask

  task automatic wait_empty(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("scoreboard_drained", 512'(sb.size()), 512'(0));
    sb.delete();
  endtask

  task automatic load_words(input int id);
    logic [3:0] oh;
    oh = 4'(1) << id;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin
        req_ref_in[j*64 +: 64]     = {16'hBEEF, 16'(j), 32'(k)};
        req_query_in[j*64 +: 64]   = {16'hCAFE, 16'(j), 32'(k)};
        req_ref_addr[j*32 +: 32]   = 32'(j*256 + k);
        req_query_addr[j*32 +: 32] = 32'(j*256 + 16 + k);
      end
      // Last word: only non-owners raise their enable, which must be ignored.
      req_ref_wr_en   = (k == 3) ? ~oh : oh;
      req_query_wr_en = oh;
      arr_done        = (k == 0);
      arr_tile_output = {16{32'hDEADBEEF}};
      #1;
      chk("ref_wr_en", 512'(arr_ref_wr_en), (k == 3) ? 512'(0) : 512'(1));
      chk("ref_word", {arr_ref_in, arr_ref_addr}, {16'hBEEF, 16'(id), 32'(k), 32'(id*256 + k)});
      chk("query_word", {arr_query_wr_en, arr_query_in, arr_query_addr},
          {1'b1, 16'hCAFE, 16'(id), 32'(k), 32'(id*256 + 16 + k)});
    end
    @(posedge clk); #1;
    req_ref_wr_en = '0; req_query_wr_en = '0; arr_done = 1'b0; arr_tile_output = '0;
  endtask

  task automatic do_start(input int id, input bit notready);
    @(posedge clk); #1;
    req_start[id] = 1'b1;
    if (notready) begin
      arr_ready = 1'b0;
      #1 chk("start_blocked", 512'(arr_start), 512'(0));
      @(posedge clk); #1;
      chk("still_load", {gnt, arr_start}, {4'(1) << id, 1'b0});
    end
    arr_ready = 1'b1;
    #1 chk("start_accept", 512'(arr_start), 512'(1));
    @(posedge clk); #1;
    req_start = '0;
    chk("start_single", 512'(arr_start), 512'(0));
  endtask

  task automatic do_tile(input int id, input logic [511:0] tile, input int ndir,
                         input logic [127:0] dbase, input bit notready, input bit drop);
    int   s0;
    exp_t e;
    logic [3:0] oh;
    oh = 4'(1) << id;
    load_words(id);
    s0 = n_starts;
    do_start(id, notready);
    if (drop) req = '0;
    arr_dir_out_valid = 1'b1; arr_dir_out = 128'hBAD;
    @(posedge clk); #1;
    arr_dir_out_valid = 1'b0;
    chk("run_grant", {gnt, rsp_valid}, {oh, 4'b0});
    for (int b = 0; b < ndir; b++) begin
      e = '{1'b0, oh, '0, dbase + 128'(b), 1'b0, 1'b0};
      sb.push_back(e);
    end
    e = '{1'b1, oh, tile, '0, 1'b0, 1'b1};
    sb.push_back(e);
    arr_done = 1'b1; arr_tile_output = tile; arr_dir_out_count = 32'(ndir);
    @(posedge clk); #1;
    arr_done = 1'b0; arr_tile_output = '0;
    for (int b = 0; b < ndir; b++) begin
      arr_dir_out_valid = 1'b1; arr_dir_out = dbase + 128'(b);
      @(posedge clk); #1;
      arr_dir_out_valid = 1'b0;
      @(posedge clk); #1;
    end
    wait_empty(30);
    chk("one_arr_start", 512'(n_starts - s0), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   s0;
    exp_t e;

    vecs[0] = '{2, {16{32'h1111_0002}}, 0, 128'h0,        1'b0};
    vecs[1] = '{1, {16{32'h2222_0001}}, 3, 128'hD000_0000, 1'b0};
    vecs[2] = '{3, {16{32'h3333_0003}}, 0, 128'h0,        1'b1};
    vecs[3] = '{0, {16{32'h4444_0000}}, 2, 128'hE000_0010, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {gnt, busy, owner_id, rsp_valid, rsp_error, dir_valid, arr_start,
                          arr_clear_done, arr_ref_wr_en, arr_query_wr_en}, '0);
    @(negedge clk) rst = 1'b1;

    // Single-requester tiles from the vector table.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      req = 4'(1) << vecs[v].id;
      wait_grant(vecs[v].id, lat);
      chk("grant_latency", 512'(lat), 512'(1));
      do_tile(vecs[v].id, vecs[v].tile, vecs[v].ndir, vecs[v].dbase, vecs[v].notready, 1'b1);
    end

    // Abort in LOAD: pointer moves to 2, so requester 3 beats 0 and 1.
    s0 = n_starts;
    req = 4'b0010;
    wait_grant(1, lat);
    req = 4'b0000;
    @(posedge clk); #1;
    chk("abort_release", {gnt, busy}, '0);
    req = 4'b1011;
    wait_grant(3, lat);
    chk("abort_regrant_latency", 512'(lat), 512'(1));
    req = 4'b0000;
    @(posedge clk); #1;
    chk("abort_no_start", {gnt, 28'(n_starts - s0)}, '0);

    // Contention with all requests held: order 0,1,2,3,0.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(i % 4, lat);
      do_tile(i % 4, {16{32'h5500_0000 + 32'(i)}}, i % 2, 128'hC000 + 128'(i*16), 1'b0, i == 4);
    end

    // Reset during DRAIN abandons the tile.
    @(posedge clk); #1;
    req = 4'b0100;
    wait_grant(2, lat);
    do_start(2, 1'b0);
    req = '0;
    e = '{1'b0, 4'b0100, '0, 128'hF00D, 1'b0, 1'b0};
    sb.push_back(e);
    arr_done = 1'b1; arr_tile_output = {16{32'h7777_7777}}; arr_dir_out_count = 32'd3;
    @(posedge clk); #1;
    arr_done = 1'b0;
    arr_dir_out_valid = 1'b1; arr_dir_out = 128'hF00D;
    @(posedge clk); #1;
    arr_dir_out_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_ctrl", {gnt, busy, owner_id, rsp_valid, rsp_error, dir_valid, arr_start,
                     arr_clear_done, arr_ref_wr_en, arr_query_wr_en}, '0);
    chk("rst_dir_data", 512'(dir_data), '0);
    chk("rst_tile", rsp_tile_output, '0);
    chk("rst_arr_bus", {arr_ref_in, arr_query_in, arr_ref_addr, arr_query_addr}, '0);
    chk("rst_sb_consumed", 512'(sb.size()), '0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // After reset the pointer is 0 again.
    @(posedge clk); #1;
    req = 4'b1010;
    wait_grant(1, lat);
    chk("post_reset_latency", 512'(lat), 512'(1));
    do_tile(1, {16{32'h8888_0001}}, 1, 128'hA0, 1'b0, 1'b1);

`ifdef GACTX_ARB_TIMEOUT_EN
    req = 4'b0001;
    wait_grant(0, lat);
    do_start(0, 1'b0);
    req = '0;
    e = '{1'b1, 4'b0001, '0, '0, 1'b1, 1'b0};
    sb.push_back(e);
    wait_empty(40);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gactx_tile_arbiter.md
GACTX_TILE_ARBITER -- requirements
Module: gactx_tile_arbiter

Interface
REQ-001 The block SHALL have the following parameters: NUM_REQ, default 4, number of requesters; LOG_NUM_REQ, default 2, width of the requester index; TIMEOUT_CYCLES, default 1048576, watchdog limit.
REQ-002 The block SHALL have one clock (clk) and an asynchronous, active-low reset (rst); the block has no other clock or reset.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, level.
- gnt  out  NUM_REQ  one-hot grant.
- req_start  in  NUM_REQ  per-requester start pulse.
- req_ref_wr_en, req_query_wr_en  in  NUM_REQ each  per-requester sequence write enables.
- req_ref_in, req_query_in  in  64*NUM_REQ each  per-requester 64-bit sequence words.
- req_ref_addr, req_query_addr  in  32*NUM_REQ each  per-requester word addresses.
- arr_start, arr_ref_wr_en, arr_query_wr_en, arr_clear_done  out  1 each  to the array wrapper.
- arr_ref_in, arr_query_in  out  64 each  to the array wrapper.
- arr_ref_addr, arr_query_addr  out  32 each  to the array wrapper.
- arr_ready, arr_done  in  1 each  wrapper ready, and done_GACT pulse.
- arr_tile_output  in  512  wrapper result word.
- arr_dir_out_count  in  32  number of direction beats.
- arr_dir_out  in  128  direction beat data.
- arr_dir_out_valid  in  1  direction beat valid.
- rsp_valid  out  NUM_REQ  one-cycle result pulse to the owner.
- rsp_tile_output  out  512  registered result.
- rsp_error  out  1  result invalid (timeout).
- dir_valid  out  NUM_REQ  forwarded direction beat, owner only.
- dir_data  out  128  forwarded direction data.
- busy  out  1  array owned.
- owner_id  out  LOG_NUM_REQ  current owner.

Function
REQ-004 The state machine SHALL have the states IDLE, LOAD, RUN, DRAIN and RESP.
REQ-005 In IDLE with any req bit high, the block SHALL pick the first requesting index at or after the round-robin pointer, register it as owner_id, assert gnt[owner] next cycle, and enter LOAD.
REQ-006 In LOAD, the owner's write enables, words and addresses SHALL be muxed combinationally onto arr_*; the write enables of non-owners SHALL be ignored.
REQ-007 In LOAD, if req_start[owner] and arr_ready are both high, the block SHALL drive arr_start=1 for exactly that cycle and enter RUN.
- If req_start[owner] is high while arr_ready is low, the block SHALL ignore the start.
REQ-008 In LOAD, if req[owner] drops before a start is accepted, the block SHALL release (gnt=0), advance the pointer to owner+1 mod NUM_REQ, and return to IDLE; no rsp_valid is issued.
REQ-009 In RUN, on arr_done the block SHALL capture arr_tile_output into rsp_tile_output and arr_dir_out_count into an internal beat count.
- Count equal to 0: the block SHALL enter RESP.
- Otherwise: the block SHALL enter DRAIN with the beat counter cleared.
REQ-010 In DRAIN, each arr_dir_out_valid beat SHALL be registered to dir_data with dir_valid[owner]=1 one cycle later and SHALL increment the beat counter; when the counter reaches the beat count, the block SHALL enter RESP.
REQ-011 In RESP, the block SHALL pulse rsp_valid[owner] for one cycle and pulse arr_clear_done for one cycle, drop gnt, set the pointer to owner+1 mod NUM_REQ, and return to IDLE.
REQ-012 The earliest re-grant SHALL occur on the cycle after RESP; a req still held by the previous owner SHALL lose to any other requester.
REQ-013 gnt SHALL always be one-hot or zero, and busy SHALL equal the OR of gnt.
REQ-014 An arr_done outside RUN, or an arr_dir_out_valid outside DRAIN, SHALL be ignored.
REQ-015 The beat counter SHALL be 32 bits wide and compared for equality only; no wrap-around is permitted.

Reset
REQ-016 While rst is low, every output SHALL be 0, the state SHALL be IDLE, the pointer and owner_id SHALL be 0, and all counters SHALL be cleared, asynchronously.
- A reset in mid-operation SHALL abandon the tile without issuing rsp_valid.

Configuration
REQ-017 With GACTX_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in RUN and DRAIN.
- When the counter reaches TIMEOUT_CYCLES, the block SHALL enter RESP with rsp_error=1 for the rsp_valid cycle.
- Without the macro, rsp_error SHALL be tied 0 and RUN/DRAIN SHALL wait indefinitely.

Structure
REQ-018 The package gactx_arb_pkg SHALL hold the state enum and the constants TILE_OUT_W=512, DIR_W=128 and SEQ_W=64.
REQ-019 The round-robin pick SHALL be a sub-module, gactx_rr_pick, taking (req, pointer) and producing (valid, index), combinational.

Verification
REQ-020 Scenario, single requester: req[2]=1; load 4 ref and 4 query words; start; arr_done with count 0 -> gnt=0100 one cycle after req, exactly one arr_start, rsp_valid=0100 one cycle, rsp_tile_output equal to the captured word.
REQ-021 Scenario, contention: req=1111 held, each tile completes -> grant order 0,1,2,3,0; gnt never has more than one bit set.
REQ-022 Scenario, direction drain: arr_dir_out_count=3 with 3 valid beats D0..D2 -> dir_valid[owner] high 3 times with data D0..D2, then rsp_valid.
REQ-023 Scenario, abort: req[1] drops in LOAD before start -> no arr_start, no rsp_valid, pointer=2, next grant goes to the lowest requester at or after index 2.
REQ-024 Scenario, start while not ready: req_start with arr_ready=0 -> no arr_start and the block stays in LOAD; a retry with arr_ready=1 is accepted.
REQ-025 Scenario, timeout (macro on, TIMEOUT_CYCLES=16) and reset: no arr_done for 16 cycles -> rsp_valid with rsp_error=1; rst low in DRAIN -> all outputs 0 immediately.
